// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
// master: pipeline side (drives request, kill); slave: the unit (drives status, result).
// Request fields are sampled only on the accept edge; status outputs are registered.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             kill;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, kill,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, kill,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide.
// Latency WIDTH+1 edges from accept to done (33 for WIDTH=32); one op per WIDTH+2 cycles.
// No backpressure: start is ignored while busy; kill aborts an op in flight without done.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        cnt;
    logic [2:0]           f3;
    logic [WIDTH-1:0]     opnd;      // multiplicand magnitude, or divisor magnitude
    logic [2*WIDTH-1:0]   acc;       // mul: {partial, multiplier}; div: {remainder, quotient}
    logic                 rneg;
    logic                 div0;
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     result_q;

    logic                 accept;
    logic                 a_sgn;
    logic                 b_sgn;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     fix_res;

    // kill wins over start, so a flush in the same cycle never launches an op
    assign accept = (state == IDLE) && bus.start && !bus.kill;

    // MUL is treated as signed x signed: the low half is identical either way
    assign a_sgn = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    assign b_sgn = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
    assign a_neg = a_sgn & bus.op_a[WIDTH-1];
    assign b_neg = b_sgn & bus.op_b[WIDTH-1];
    assign a_abs = a_neg ? -bus.op_a : bus.op_a;
    assign b_abs = b_neg ? -bus.op_b : bus.op_b;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: WIDTH CALC cycles then one FIX cycle; kill drops back to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (bus.kill) state_nxt = IDLE;
                     else if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        acc_step = {1'b0, acc[2*WIDTH-1:1]};
        if (f3[2]) begin
            if (div_diff[WIDTH]) acc_step = {acc[2*WIDTH-2:0], 1'b0};
            else                 acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else if (acc[0]) begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign fix-up and result select. Signed overflow (most-negative / -1) needs no
    // override: magnitude 2^(W-1) / 1 gives quotient 2^(W-1), remainder 0, and
    // negating 2^(W-1) leaves it unchanged. Divide by zero leaves remainder = |a|
    // with sign(a), i.e. op_a; only the quotient needs forcing to all-ones.
    always_comb begin
        prod    = rneg ? -acc : acc;
        quo     = rneg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem     = rneg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_res = rem;
        case (f3)
            3'b000:                 fix_res = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_res = div0 ? '1 : quo;
            default:                fix_res = rem;
        endcase
    end

    // Operand capture on accept, then one accumulator step per CALC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            f3   <= '0;
            opnd <= '0;
            acc  <= '0;
            rneg <= 1'b0;
            div0 <= 1'b0;
        end else if (accept) begin
            cnt  <= '0;
            f3   <= bus.funct3;
            opnd <= bus.funct3[2] ? b_abs : a_abs;
            acc  <= {{WIDTH{1'b0}}, (bus.funct3[2] ? a_abs : b_abs)};
            rneg <= (bus.funct3[2] && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
            div0 <= (bus.op_b == '0);
        end else if (state == CALC) begin
            acc <= acc_step;
            cnt <= cnt + CW'(1);
        end
    end

    // Registered status and result; result only moves on a completed FIX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            busy_q <= (state_nxt != IDLE);
            done_q <= (state == FIX) && !bus.kill;
            if ((state == FIX) && !bus.kill) result_q <= fix_res;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for results/latency, plus
// hand sequences for start-while-busy, back-to-back, kill and async reset.
module tb_muldiv_unit;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Caller is at a negedge. Issues one op, optionally injects a MUL 3x3 start at
    // cycle inj_k or a kill at cycle kill_k, and returns in the done cycle (or after
    // 40 cycles with lat = -1). k counts clock edges since the accept edge.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int inj_k, input int kill_k,
                          output int lat, output logic [31:0] res,
                          output logic busy0, output logic busy_done);
        int k;
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.kill   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        busy0     = bus.busy;
        lat       = -1;
        res       = bus.result;
        busy_done = 1'b1;
        k         = 0;
        while (lat < 0 && k <= 40) begin
            if (bus.done) begin
                lat       = k;
                res       = bus.result;
                busy_done = bus.busy;
            end else begin
                bus.start = (k == inj_k);
                if (k == inj_k) begin
                    bus.funct3 = 3'b000;
                    bus.op_a   = 32'd3;
                    bus.op_b   = 32'd3;
                end else begin
                    bus.funct3 = 3'($urandom_range(7));
                    bus.op_a   = $urandom;
                    bus.op_b   = $urandom;
                end
                bus.kill = (k == kill_k);
                @(negedge clk);
                k++;
            end
        end
        bus.start = 1'b0;
        bus.kill  = 1'b0;
    endtask

    initial begin
        int          lat;
        int          c1;
        int          ndone;
        logic [31:0] res;
        logic        b0;
        logic        bd;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[6]  = '{3'b101, 32'hFFFF_FFFE, 32'h0000_0003, 32'h5555_5554};
        vecs[7]  = '{3'b111, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002};
        vecs[8]  = '{3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[9]  = '{3'b110, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[12] = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[13] = '{3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};
        vecs[14] = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFFF};
        vecs[15] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[16] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
        vecs[17] = '{3'b011, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
        vecs[18] = '{3'b010, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        vecs[19] = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.kill   = 1'b0;
        bus.funct3 = 3'b000;
        bus.op_a   = '0;
        bus.op_b   = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", bus.busy, 1'b0);
        chk("reset done", bus.done, 1'b0);
        chk("reset result", bus.result, 32'h0);
        rst = 1'b0;

        // Result table: value, 33-edge latency, busy right after accept, busy low with done
        for (int i = 0; i < 20; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, -1, -1, lat, res, b0, bd);
            chk($sformatf("vec%0d result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d latency", i), lat, 33);
            chk($sformatf("vec%0d busy after accept", i), b0, 1'b1);
            chk($sformatf("vec%0d busy with done", i), bd, 1'b0);
            @(negedge clk);
        end

        // Start while busy is ignored; then back-to-back start in the done cycle
        run_op(3'b101, 32'hFFFF_FFFE, 32'h3, 10, -1, lat, res, b0, bd);
        chk("busy-start result", res, 32'h5555_5554);
        chk("busy-start latency", lat, 33);
        c1 = cyc;
        run_op(3'b000, 32'd3, 32'd3, -1, -1, lat, res, b0, bd);
        chk("b2b result", res, 32'd9);
        chk("b2b done spacing", cyc - c1, 34);
        @(negedge clk);
        chk("b2b busy after done", bus.busy, 1'b0);

        // Kill at cycle 15: no done, result keeps previous value
        run_op(3'b000, 32'h1234, 32'h10, -1, 14, lat, res, b0, bd);
        chk("kill no done", lat, -1);
        chk("kill result held", bus.result, 32'd9);
        chk("kill busy", bus.busy, 1'b0);

        // Kill together with start in IDLE does not launch an op
        bus.start  = 1'b1;
        bus.kill   = 1'b1;
        bus.funct3 = 3'b000;
        bus.op_a   = 32'd5;
        bus.op_b   = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        chk("kill+start busy", bus.busy, 1'b0);
        ndone = 0;
        repeat (36) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("kill+start no done", ndone, 0);
        chk("kill+start result", bus.result, 32'd9);

        // Async reset mid-CALC clears outputs immediately
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.op_a   = 32'h1234;
        bus.op_b   = 32'h5678;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre-reset busy", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst busy", bus.busy, 1'b0);
        chk("midrst done", bus.done, 1'b0);
        chk("midrst result", bus.result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op(3'b000, 32'd2, 32'd2, -1, -1, lat, res, b0, bd);
        chk("post-reset result", res, 32'd4);
        chk("post-reset latency", lat, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage. It accepts two operands and a funct3 opcode, computes the result over a fixed number of cycles, and presents it on `result` with a one-cycle `done` pulse. The result feeds one data input of the writeback result-select multiplexer. While the unit is busy, the pipeline stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand and result width. Must be even and ≥ 4.
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a new operation; accepted only in IDLE.
- `funct3`, input, 3: operation select, sampled with `start`.
- `op_a`, input, WIDTH: rs1 operand (multiplicand or dividend), sampled with `start`.
- `op_b`, input, WIDTH: rs2 operand (multiplier or divisor), sampled with `start`.
- `kill`, input, 1: synchronous abort of an in-flight operation (pipeline flush).
- `busy`, output, 1: high while an operation is in flight.
- `done`, output, 1: one-cycle pulse; `result` is valid in that cycle.
- `result`, output, WIDTH: final result; holds its value until the next `done`.

## Operation
- funct3 encodings:
  - 000 MUL: low WIDTH bits of the product.
  - 001 MULH: high WIDTH bits, signed×signed.
  - 010 MULHSU: high WIDTH bits, signed `op_a` × unsigned `op_b`.
  - 011 MULHU: high WIDTH bits, unsigned×unsigned.
  - 100 DIV: signed quotient. 101 DIVU: unsigned quotient.
  - 110 REM: signed remainder. 111 REMU: unsigned remainder.
- States are IDLE, CALC and FIX.
- IDLE with `start`=1:
  - Capture the operand magnitudes (two's-complement absolute value where the operand is signed).
  - Record the result sign, clear the iteration counter, go to CALC.
- CALC performs one iteration per cycle, WIDTH iterations in total, then goes to FIX.
  - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, WIDTH-bit quotient and remainder.
- FIX:
  - Apply sign correction: negate the 2·WIDTH product if the operand signs differ; quotient takes sign(a)^sign(b); remainder takes sign(a).
  - Apply the special cases below, register `result`, pulse `done`, return to IDLE.
- Special cases are resolved in FIX and keep the same latency:
  - Divide by zero: DIV and DIVU give all-ones; REM and REMU give `op_a` unchanged.
  - Signed overflow (`op_a` = most-negative, `op_b` = −1): DIV gives most-negative; REM gives 0.
- `start` while `busy`=1 is ignored. Operand changes after the accept edge have no effect.
- `kill`=1 in CALC or FIX returns the unit to IDLE at the next edge. No `done` is produced, and `result` is not updated.
- `kill` takes priority over `start`. In IDLE, `kill`=1 with `start`=1 does not start an operation.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, all internal registers 0.
- Reset takes effect immediately, including mid-operation. The first edge after reset deassertion can accept `start`.
- Edge E0 samples `start`=1 in IDLE. `busy` is high from after E0 until after edge E0+WIDTH+1.
- CALC iterations occur at edges E0+1 through E0+WIDTH.
- The FIX result is registered at edge E0+WIDTH+1.
- `done`=1 for exactly the cycle following E0+WIDTH+1, with `busy`=0 in that cycle. Latency is 33 cycles for WIDTH=32.
- `done` and `busy` are never high together.
- `start` may be asserted during the `done` cycle. It is accepted at that cycle's closing edge, so throughput is one operation every WIDTH+2 cycles.
- `busy` and `done` are registered outputs, with no combinational path from inputs.

## Test plan
- **MUL:** reset, then `start` with MUL, `op_a`=7, `op_b`=0xFFFFFFFD. Required: `result`=0xFFFFFFEB, and `done` in exactly the 33rd cycle after the accept edge.
- **High-word multiplies:**
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- **Divide and remainder:**
  - DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFFE/3 → 0x55555554. REMU → 2.
- **Special cases:**
  - DIVU 5/0 → 0xFFFFFFFF. REM 0xFFFFFFFB/0 → 0xFFFFFFFB.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM → 0.
  - Each completes with the normal 33-cycle latency.
- **Start while busy, back-to-back:** a second `start` with MUL 3×3 at cycle 10 of an operation is ignored, and the first result is unchanged. A `start` with MUL 3×3 in the `done` cycle yields 9 exactly 34 cycles after the first `done`.
- **Kill and reset:** `kill` at cycle 15 of an operation gives no `done`, and `result` keeps its previous value. `rst` pulsed mid-CALC forces `busy`=0, `done`=0 and `result`=0 immediately. A following MUL 2×2 returns 4.
